// File: rtl/plane_recip_div_pkg.sv
// Shared constants and types for the per-scanline perspective reciprocal divider.
package plane_recip_div_pkg;

    localparam int RECIP_NUM_SHIFT  = 16;  // numerator is 2^RECIP_NUM_SHIFT
    localparam int RECIP_DEN_W      = 10;  // unsigned divisor width
    localparam int RECIP_OUT_W      = 11;  // quotient width and cycles per division

    // Any denominator at or below this value yields a quotient that does not
    // fit in RECIP_OUT_W bits, so the result is clamped to all-ones.
    localparam int RECIP_SAT_THRESH = 1 << (RECIP_NUM_SHIFT - RECIP_OUT_W);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/plane_recip_div.sv
// Iterative restoring divider: recip = floor(2^NUM_SHIFT / denom), one quotient
// bit per clock, constant latency of OUT_W cycles, saturating to all-ones.
module plane_recip_div
    import plane_recip_div_pkg::*;
#(
    parameter int NUM_SHIFT = RECIP_NUM_SHIFT,
    parameter int DEN_W     = RECIP_DEN_W,
    parameter int OUT_W     = RECIP_OUT_W
) (
    input  logic             clk48,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DEN_W-1:0] denom,
    output logic [OUT_W-1:0] recip,
    output logic             busy,
    output logic             done
);

    localparam int REM_W = NUM_SHIFT + 1;          // holds 2^NUM_SHIFT exactly
    localparam int DIV_W = DEN_W + OUT_W - 1;      // denom pre-shifted to the top quotient bit
    localparam int CMP_W = (DIV_W > REM_W) ? DIV_W : REM_W;
    localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int unsigned SAT_THRESH = 2 ** (NUM_SHIFT - OUT_W);

    typedef struct packed {
        logic [REM_W-1:0] rem;
        logic             q;
    } step_t;

    // One restoring step: subtract the aligned divisor when it fits and emit
    // the corresponding quotient bit. Compared at full width, unsigned.
    function automatic step_t recip_step(input logic [REM_W-1:0] r,
                                         input logic [DIV_W-1:0] d);
        logic [CMP_W-1:0] rx;
        logic [CMP_W-1:0] dx;
        step_t            s;
        rx    = CMP_W'(r);
        dx    = CMP_W'(d);
        s.rem = r;
        s.q   = 1'b0;
        if (rx >= dx) begin
            s.rem = REM_W'(rx - dx);
            s.q   = 1'b1;
        end
        return s;
    endfunction

    state_t           state;
    state_t           state_next;
    logic [REM_W-1:0] rem;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] count;
    logic [OUT_W-1:0] quot;
    logic             sat;
    step_t            st;
    logic             last_step;
    logic             sat_in;

    assign busy      = (state == RUN);
    assign last_step = (count == '0);
    assign sat_in    = (denom == '0) || (32'(denom) <= SAT_THRESH);

    // Evaluate the current step from the live remainder and divisor.
    always_comb begin
        st = recip_step(rem, div);
    end

    // State register.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_next;
        end
    end

    // Next-state logic: start always (re)enters RUN, completion returns to IDLE.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                if (start)          state_next = RUN;
                else if (last_step) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on start, iterate while running, publish on completion.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= '0;
            div   <= '0;
            count <= '0;
            quot  <= '0;
            sat   <= 1'b0;
            recip <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // A start always wins: it aborts any division in flight,
                // including one that would otherwise complete on this edge.
                rem   <= REM_W'(1) << NUM_SHIFT;
                div   <= DIV_W'(denom) << (OUT_W - 1);
                count <= CNT_W'(OUT_W - 1);
                quot  <= '0;
                sat   <= sat_in;
            end else if (state == RUN) begin
                rem         <= st.rem;
                div         <= div >> 1;
                quot[count] <= st.q;
                count       <= count - 1'b1;
                if (last_step) begin
                    recip <= sat ? '1 : {quot[OUT_W-1:1], st.q};
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_plane_recip_div.sv
// Directed self-checking bench for plane_recip_div with an expected-result queue.
module tb_plane_recip_div;

    logic        clk48 = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  denom;
    logic [10:0] recip;
    logic        busy;
    logic        done;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_q[$];
    logic [10:0] last_recip;

    plane_recip_div dut (
        .clk48 (clk48),
        .rst_n (rst_n),
        .start (start),
        .denom (denom),
        .recip (recip),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk48 = ~clk48;

    function automatic int model(input int d);
        if (d == 0 || d <= 32) return 2047;
        return 65536 / d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge.
    task automatic do_start(input logic [9:0] d, input bit push);
        if (push) exp_q.push_back(model(int'(d)));
        start = 1'b1;
        denom = d;
        @(negedge clk48);
        start = 1'b0;
        denom = 10'($urandom);
    endtask

    // Wait (bounded) for done, then check latency, hold behaviour and result.
    task automatic wait_done(input string tag);
        int lat       = -1;
        bit unstable  = 1'b0;
        bit busy_bad  = 1'b0;
        int want      = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk48);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            if (recip !== last_recip) unstable = 1'b1;
            if (busy !== 1'b1)        busy_bad = 1'b1;
        end
        check({tag, "_latency"}, lat, 11);
        check({tag, "_held"}, 32'(unstable), 0);
        check({tag, "_busy_run"}, 32'(busy_bad), 0);
        check({tag, "_busy_end"}, 32'(busy), 0);
        if (exp_q.size() != 0) want = exp_q.pop_front();
        check({tag, "_recip"}, 32'(recip), want);
        last_recip = recip;
        @(negedge clk48);
        check({tag, "_done_width"}, 32'(done), 0);
    endtask

    initial begin
        int pulses;
        bit spurious;
        bit shown;

        rst_n = 1'b0;
        start = 1'b0;
        denom = '0;
        #12;
        check("rst_recip", 32'(recip), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        @(negedge clk48);
        rst_n      = 1'b1;
        last_recip = '0;
        @(negedge clk48);

        // Basic division with full timing checks.
        do_start(10'd34, 1'b1);
        check("d34_busy_edge1", 32'(busy), 1);
        wait_done("d34");

        // Sweep.
        do_start(10'd33, 1'b1);   wait_done("d33");
        do_start(10'd512, 1'b1);  wait_done("d512");
        do_start(10'd1023, 1'b1); wait_done("d1023");

        // Saturation.
        do_start(10'd32, 1'b1);   wait_done("sat32");
        do_start(10'd1, 1'b1);    wait_done("sat1");
        do_start(10'd0, 1'b1);    wait_done("sat0");

        // Reset mid-run: start at cycle 0, reset asserted during cycle 4.
        do_start(10'd100, 1'b0);
        repeat (3) @(negedge clk48);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_recip", 32'(recip), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        @(negedge clk48);
        @(negedge clk48);
        rst_n    = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk48);
            if (done !== 1'b0 || recip !== 11'd0) spurious = 1'b1;
        end
        check("midrst_quiet", 32'(spurious), 0);
        last_recip = '0;
        do_start(10'd100, 1'b1);
        wait_done("post_rst");

        // Restart: denom 100 at edge 0, denom 200 at edge 5.
        do_start(10'd100, 1'b0);
        spurious = 1'b0;
        repeat (4) begin
            @(negedge clk48);
            if (done !== 1'b0 || recip !== last_recip) spurious = 1'b1;
        end
        check("restart_pre_quiet", 32'(spurious), 0);
        do_start(10'd200, 1'b1);
        wait_done("restart");

        // Start on the completion edge discards the finishing result.
        do_start(10'd100, 1'b0);
        repeat (10) @(negedge clk48);
        do_start(10'd50, 1'b1);
        check("collide_no_done", 32'(done), 0);
        check("collide_recip_held", 32'(recip), 32'(last_recip));
        wait_done("collide");

        // start held for three cycles: only the last denom completes.
        exp_q.push_back(model(80));
        start = 1'b1;
        denom = 10'd40;
        @(negedge clk48);
        denom = 10'd60;
        @(negedge clk48);
        denom = 10'd80;
        @(negedge clk48);
        start = 1'b0;
        denom = 10'($urandom);
        wait_done("held");

        // Line-rate soak: one start per 1525-cycle line, sampled 16 cycles later.
        for (int k = 0; k < 10; k++) begin
            int d;
            int want;
            d = 34 + (k * 239) / 9;
            do_start(10'(d), 1'b1);
            pulses = 0;
            shown  = 1'b0;
            repeat (16) begin
                @(negedge clk48);
                if (done === 1'b1) pulses++;
            end
            want = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            check($sformatf("soak_d%0d_pulses", d), pulses, 1);
            check($sformatf("soak_d%0d_recip", d), 32'(recip), want);
            last_recip = recip;
            repeat (1525 - 17) @(negedge clk48);
        end

        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
